// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if
//   Bundles the load/store request handshake, the response channel and the
//   word-wide data-memory port used by dm_access_ctrl.
//   Modports:
//     slave  - the load/store unit. It takes requests, returns responses and
//              drives the memory strobes.
//     master - its environment. It issues requests, receives responses and
//              supplies mem_rdata.
//   Signals:
//     req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata
//     rsp_valid/rsp_rdata/rsp_err
//     mem_write/mem_read/mem_addr/mem_wdata/mem_rdata
interface dm_access_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [ADDR_WIDTH+1:0]   req_addr;
  logic [WORD_WIDTH-1:0]   req_wdata;

  logic                    rsp_valid;
  logic [WORD_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  logic                    mem_write;
  logic                    mem_read;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [WORD_WIDTH-1:0]   mem_wdata;
  logic [WORD_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_write, mem_read, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_write, mem_read, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
//   MEM-stage load/store unit driving a word-wide data memory that has a
//   1-cycle read latency. It accepts byte/half/word requests one at a time.
//   Sub-word stores are done as read-modify-write. Sub-word loads are
//   sign- or zero-extended. Each accepted request gets exactly one response,
//   either data or a misalignment error.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset
//     bus  - dm_access_ctrl_if.slave: request/response handshake and memory port
module dm_access_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  dm_access_ctrl_if.slave   bus
);

  localparam int LANES  = 4;
  localparam int LANE_W = WORD_WIDTH / LANES;
  localparam int HALF_W = 2 * LANE_W;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    RMW_RD,
    RMW_WAIT,
    WR,
    RESP
  } state_t;

  state_t                  state_reg, state_next;

  // Request fields captured on the accept edge
  logic [1:0]              size_reg, size_next;
  logic                    unsigned_reg, unsigned_next;
  logic [1:0]              lane_reg, lane_next;
  logic [WORD_WIDTH-1:0]   wdata_reg, wdata_next;

  // Registered outputs
  logic                    mem_write_reg, mem_write_next;
  logic                    mem_read_reg, mem_read_next;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
  logic [WORD_WIDTH-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic [WORD_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                    rsp_err_reg, rsp_err_next;

  logic                    accept;
  logic                    misaligned;
  logic [LANES-1:0]        lane_en;
  logic [WORD_WIDTH-1:0]   merge_data;
  logic [LANE_W-1:0]       rd_byte [LANES];
  logic [LANE_W-1:0]       sel_byte;
  logic [HALF_W-1:0]       sel_half;
  logic [WORD_WIDTH-1:0]   load_data;

  assign bus.req_ready = (state_reg == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  assign misaligned = (bus.req_size == 2'b11) ||
                      ((bus.req_size == SIZE_HALF) && bus.req_addr[0]) ||
                      ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));

  // Per-lane store merge. A lane takes store data when the access covers it.
  // Otherwise it keeps the word just read back.
  // The store data is right-aligned, so it has to be steered to the target lane:
  // - a byte always comes from wdata lane 0;
  // - a half comes from wdata lane 0 or 1;
  // - a word maps straight across.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE_IDX = 2'(gi);
      localparam int         HALF_SRC = gi % 2;
      logic [LANE_W-1:0]     store_byte;

      assign rd_byte[gi] = bus.mem_rdata[gi*LANE_W +: LANE_W];

      assign lane_en[gi] = (size_reg == SIZE_WORD) ||
                           ((size_reg == SIZE_HALF) && (lane_reg[1] == LANE_IDX[1])) ||
                           ((size_reg == SIZE_BYTE) && (lane_reg == LANE_IDX));

      assign store_byte = (size_reg == SIZE_BYTE) ? wdata_reg[LANE_W-1:0] :
                          (size_reg == SIZE_HALF) ? wdata_reg[HALF_SRC*LANE_W +: LANE_W] :
                                                    wdata_reg[gi*LANE_W +: LANE_W];

      assign merge_data[gi*LANE_W +: LANE_W] = lane_en[gi] ? store_byte : rd_byte[gi];
    end
  endgenerate

  // Little-endian lane extraction and extension for loads
  assign sel_byte = rd_byte[lane_reg];
  assign sel_half = lane_reg[1] ? bus.mem_rdata[HALF_W +: HALF_W] : bus.mem_rdata[0 +: HALF_W];

  always_comb begin
    load_data = bus.mem_rdata;
    case (size_reg)
      SIZE_BYTE: load_data = {{(WORD_WIDTH-LANE_W){!unsigned_reg && sel_byte[LANE_W-1]}}, sel_byte};
      SIZE_HALF: load_data = {{(WORD_WIDTH-HALF_W){!unsigned_reg && sel_half[HALF_W-1]}}, sel_half};
      default:   load_data = bus.mem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_next     = state_reg;
    size_next      = size_reg;
    unsigned_next  = unsigned_reg;
    lane_next      = lane_reg;
    wdata_next     = wdata_reg;
    mem_write_next = 1'b0;
    mem_read_next  = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          size_next     = bus.req_size;
          unsigned_next = bus.req_unsigned;
          lane_next     = bus.req_addr[1:0];
          wdata_next    = bus.req_wdata;
          mem_addr_next = bus.req_addr[ADDR_WIDTH+1:2];
          if (misaligned) begin
            // The error response goes out directly. The memory is never touched.
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
            state_next     = RESP;
          end else if (!bus.req_we) begin
            mem_read_next = 1'b1;
            state_next    = RD;
          end else if (bus.req_size == SIZE_WORD) begin
            mem_write_next = 1'b1;
            mem_wdata_next = bus.req_wdata;
            state_next     = WR;
          end else begin
            mem_read_next = 1'b1;
            state_next    = RMW_RD;
          end
        end
      end
      RD:       state_next = RD_WAIT;
      RD_WAIT: begin
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = load_data;
        state_next     = RESP;
      end
      RMW_RD:   state_next = RMW_WAIT;
      RMW_WAIT: begin
        mem_write_next = 1'b1;
        mem_wdata_next = merge_data;
        state_next     = WR;
      end
      WR: begin
        // Write strobe is on the bus this cycle, so the store completes here
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = '0;
        state_next     = RESP;
      end
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      size_reg      <= '0;
      unsigned_reg  <= 1'b0;
      lane_reg      <= '0;
      wdata_reg     <= '0;
      mem_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      size_reg      <= size_next;
      unsigned_reg  <= unsigned_next;
      lane_reg      <= lane_next;
      wdata_reg     <= wdata_next;
      mem_write_reg <= mem_write_next;
      mem_read_reg  <= mem_read_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  // A write already registered for this cycle is suppressed when rst is
  // asserted, so a dropped request can never reach the memory.
  assign bus.mem_write = mem_write_reg && !rst;
  assign bus.mem_read  = mem_read_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;

endmodule
